if_fetch: RTL
=============

Name: if_fetch

Overview:
- Instruction-fetch stage: producer side of the IF/ID pipeline register.
- Holds the PC and runs a req/ack handshake to instruction ROM/bus.
- Presents if_pc/if_inst/if_valid to IF/ID.
- Honours ctrl stall, exception flush and MIPS branch redirect; the instruction after a branch is the delay slot and is fetched normally.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset
- ADDR_W, 32, PC/address width
- INST_W, 32, instruction width

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; synchronous, active-high (`RstEnable` = 1'b1)
- stall_i  input  1  ctrl stall; IF outputs hold and no new request is issued
- flush_i  input  1  exception flush; redirect to new_pc_i
- new_pc_i  input  ADDR_W  exception handler address
- branch_flag_i  input  1  branch taken, from ID
- branch_target_i  input  ADDR_W  branch target, from ID
- rom_req_o  output  1  fetch request
- rom_addr_o  output  ADDR_W  fetch address; stable while req high
- rom_ack_i  input  1  data valid; may assert in the same cycle req is first high
- rom_data_i  input  INST_W  fetched word
- if_pc  output  ADDR_W  PC to IF/ID
- if_inst  output  INST_W  instruction to IF/ID
- if_valid  output  1  if_pc/if_inst hold a real fetched instruction

Behaviour:
- Reset:
  - pc=RESET_PC; rom_req_o=0; rom_addr_o=0.
  - if_pc=0, if_inst=0, if_valid=0.
  - pend_redirect=0, discard=0; state IDLE.
  - rst mid-transaction abandons the outstanding request. The ROM is reset on the same rst.
- States:
  - IDLE: first cycle after reset or while stalled with nothing outstanding.
  - REQ: rom_req_o=1, rom_addr_o=pc, waiting for ack.
  - HOLD: word received while stalled, parked in an internal buffer.
- Transitions:
  - IDLE→REQ when stall_i=0.
  - REQ, ack, stall_i=0:
    - Registered outputs update next edge: if_pc<=pc, if_inst<=rom_data_i, if_valid<=1.
    - pc<=next_pc; remain REQ with the new address.
    - Throughput is 1 instr/cycle against a zero-wait ROM.
  - REQ, ack, stall_i=1: word and pc captured in the buffer; →HOLD; rom_req_o drops next cycle.
  - REQ, no ack: hold req and addr unchanged; a stall does not withdraw the request.
  - HOLD, stall_i=0: outputs load from the buffer; →REQ at next_pc.
  - stall_i=1 in REQ/HOLD/IDLE: if_pc/if_inst/if_valid hold their values.
- next_pc:
  - pend_redirect ? pend_target : pc+4.
  - Add is modulo 2^ADDR_W; 32'hFFFF_FFFC wraps to 0.
- Branch:
  - branch_flag_i=1 with stall_i=0 sets pend_redirect=1, pend_target=branch_target_i.
  - It is consumed (cleared) at the next accepted ack (the delay-slot fetch).
  - Branch and ack in the same cycle: the acked word is the delay slot and the new pc=branch_target_i directly.
  - A second branch before consumption overwrites pend_target.
- Flush (priority over stall and branch):
  - if_valid<=0, if_inst<=0, if_pc<=0.
  - pend_redirect<=0; pc<=new_pc_i; HOLD buffer dropped.
  - Request outstanding without ack that cycle: set discard; the next ack is dropped, then fetch new_pc_i.
  - Otherwise: →REQ at new_pc_i next cycle.
- Alignment: low 2 bits of new_pc_i/branch_target_i forced to 0.
- Priority: rst > flush_i > stall_i > ack/branch.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- Defined:
  - Adds output perf_fetch_cnt (32): counts instructions delivered with if_valid rising per accepted word.
  - Adds output perf_wait_cnt (32): counts cycles with rom_req_o=1 and rom_ack_i=0.
  - Both reset to 0 on rst, wrap at 2^32 and are not cleared by flush.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Zero-wait ROM, ack tied high after reset → rom_addr_o 0,4,8,C on consecutive cycles; if_pc trails by one cycle; if_valid=1 continuously.
- Ack delayed 3 cycles on addr 0x8 → rom_req_o/addr 0x8 stable 3 cycles; if_pc/if_inst unchanged until the ack edge.
- branch_flag_i=1 to target 0x100 while fetching 0x14 → 0x14 delivered (delay slot), next addr 0x100, then 0x104.
- stall_i high 4 cycles, ack arriving during stall at 0x20 → outputs frozen; on release if_pc=0x20 with the correct word; next request 0x24, no refetch of 0x20.
- flush_i with new_pc_i=0x180 while a request to 0x30 is outstanding, ack 2 cycles later → if_valid=0; 0x30 word dropped; next request 0x180; no branch applied.
- IF_PERF_CNT_EN defined, 10 fetches with 5 wait cycles → perf_fetch_cnt=10, perf_wait_cnt=5; rst returns both to 0.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC register, ROM req/ack handshake and the IF side of IF/ID.
// Optional IF_PERF_CNT_EN adds fetch and wait-cycle counters.
module if_fetch #(
  parameter int unsigned            ADDR_W   = 32,
  parameter int unsigned            INST_W   = 32,
  parameter logic [ADDR_W-1:0]      RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] new_pc_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic              rom_req_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic              rom_ack_i,
  input  logic [INST_W-1:0] rom_data_i,
  output logic [ADDR_W-1:0] if_pc,
  output logic [INST_W-1:0] if_inst,
  output logic              if_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_wait_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   if_pc_q, if_pc_d;
  logic [INST_W-1:0]   if_inst_q, if_inst_d;
  logic                if_valid_q, if_valid_d;
  logic                pend_redirect_q, pend_redirect_d;
  logic [ADDR_W-1:0]   pend_target_q, pend_target_d;
  logic                discard_q, discard_d;
  logic [ADDR_W-1:0]   disc_addr_q, disc_addr_d;
  logic [INST_W-1:0]   buf_inst_q, buf_inst_d;

  logic                accept;
  logic [INST_W-1:0]   accept_word;
  logic [ADDR_W-1:0]   next_seq;

  // While a flushed request drains, the old address stays on the bus until its ack.
  assign rom_req_o  = (state_q == REQ);
  assign rom_addr_o = (state_q == REQ) ? (discard_q ? disc_addr_q : pc_q) : '0;
  assign if_pc      = if_pc_q;
  assign if_inst    = if_inst_q;
  assign if_valid   = if_valid_q;

  assign next_seq = pend_redirect_q ? pend_target_q : pc_q + ADDR_W'(4);

  always_comb begin
    accept      = 1'b0;
    accept_word = rom_data_i;
    if (!flush_i && !stall_i) begin
      if (state_q == REQ && rom_ack_i && !discard_q) begin
        accept = 1'b1;
      end else if (state_q == HOLD) begin
        accept      = 1'b1;
        accept_word = buf_inst_q;
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    if_pc_d         = if_pc_q;
    if_inst_d       = if_inst_q;
    if_valid_d      = if_valid_q;
    pend_redirect_d = pend_redirect_q;
    pend_target_d   = pend_target_q;
    discard_d       = discard_q;
    disc_addr_d     = disc_addr_q;
    buf_inst_d      = buf_inst_q;

    if (flush_i) begin
      if_valid_d      = 1'b0;
      if_inst_d       = '0;
      if_pc_d         = '0;
      pend_redirect_d = 1'b0;
      pc_d            = align_addr(new_pc_i);
      state_d         = REQ;
      if (state_q == REQ && !rom_ack_i) begin
        discard_d = 1'b1;
        if (!discard_q) disc_addr_d = pc_q;
      end else begin
        discard_d = 1'b0;
      end
    end else if (accept) begin
      if_pc_d         = pc_q;
      if_inst_d       = accept_word;
      if_valid_d      = 1'b1;
      pc_d            = branch_flag_i ? align_addr(branch_target_i) : next_seq;
      pend_redirect_d = 1'b0;
      state_d         = REQ;
    end else begin
      case (state_q)
        IDLE: if (!stall_i) state_d = REQ;
        REQ: begin
          if (rom_ack_i && discard_q) begin
            discard_d = 1'b0;
            if (stall_i) state_d = IDLE;
          end else if (rom_ack_i && stall_i) begin
            buf_inst_d = rom_data_i;
            state_d    = HOLD;
          end
        end
        default: ;
      endcase
      if (!stall_i && branch_flag_i) begin
        pend_redirect_d = 1'b1;
        pend_target_d   = align_addr(branch_target_i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      pc_q            <= RESET_PC;
      if_pc_q         <= '0;
      if_inst_q       <= '0;
      if_valid_q      <= 1'b0;
      pend_redirect_q <= 1'b0;
      discard_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      if_pc_q         <= if_pc_d;
      if_inst_q       <= if_inst_d;
      if_valid_q      <= if_valid_d;
      pend_redirect_q <= pend_redirect_d;
      discard_q       <= discard_d;
    end
  end

  always_ff @(posedge clk) begin
    pend_target_q <= pend_target_d;
    disc_addr_q   <= disc_addr_d;
    buf_inst_q    <= buf_inst_d;
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q + (accept ? 32'd1 : 32'd0);
    wait_cnt_d  = wait_cnt_q + ((rom_req_o && !rom_ack_i) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_wait_cnt  = wait_cnt_q;
`endif

endmodule
